regfile_wb: RTL and testbench
=============================

// Module: regfile_wb
// PURPOSE
//   General-purpose register file at the far end of the MEM/WB pipeline register.
//   Accepts the registered write-back triple (address, enable, data) each cycle.
//   Serves two asynchronous read ports to the ID stage.
//   Register 0 is hardwired to zero. A same-cycle write to a register being read is bypassed to the read port.
// PARAMETERS
//   DATA_W    32   width of each register and of all data ports
//   ADDR_W    5    register address width
//   NUM_REGS  32   number of registers; must equal 2**ADDR_W
// PORTS
//   clk     in   1       clock; all state updates on the rising edge
//   rst     in   1       reset rst, synchronous, active-high
//   we      in   1       write enable, driven from wb_wreg
//   waddr   in   ADDR_W  write register address, driven from wb_wd
//   wdata   in   DATA_W  write data, driven from wb_wdata
//   re1     in   1       read port 1 enable
//   raddr1  in   ADDR_W  read port 1 address
//   rdata1  out  DATA_W  read port 1 data (combinational)
//   re2     in   1       read port 2 enable
//   raddr2  in   ADDR_W  read port 2 address
//   rdata2  out  DATA_W  read port 2 data (combinational)
// BEHAVIOUR
//   Storage
//   - Array regs[1..NUM_REGS-1] of DATA_W bits. No storage exists for index 0.
//   Reset
//   - On a rising edge with rst=1, every regs[i] is cleared to 0 and the write is ignored.
//   - While rst=1, rdata1 and rdata2 are forced to 0, independent of any enable or address.
//   - Asserting rst mid-sequence discards any write presented in that cycle.
//   Write
//   - On a rising edge with rst=0, we=1 and waddr!=0: regs[waddr] <= wdata.
//   - When waddr=0, the write is silently dropped.
//   - When we=0, no state changes.
//   Read (port n = 1 or 2; purely combinational, zero-cycle latency), evaluated in this priority order:
//     1. rst=1                                   -> 0
//     2. raddr_n=0                               -> 0 (regardless of we/waddr)
//     3. re_n=0                                  -> 0
//     4. we=1 && waddr==raddr_n                  -> wdata (write-through bypass)
//     5. otherwise                               -> regs[raddr_n]
//   - The bypass (case 4) lets the ID stage see a value being retired in the same cycle, so no extra stall is needed for a distance-3 RAW hazard.
//   - Both ports may read the same address in the same cycle; both return identical values.
//   - Both ports may match the write address simultaneously; both are bypassed.
//   - Read-during-write to a different address returns the old contents of the read address.
//   - No X may propagate to rdata when an enable or address is X and rst=1.
// TESTING
//   1. Reset: hold rst=1 for 2 cycles with we=1 waddr=5 wdata=32'hDEAD_BEEF, then read r5 -> rdata=0; r5 remains 0.
//   2. Basic write/read: write r7=32'h1234_5678, next cycle re1=1 raddr1=7 -> rdata1=32'h1234_5678; re1=0 -> 0.
//   3. Zero register: we=1 waddr=0 wdata=32'hFFFF_FFFF, then read r0 on both ports, same cycle and next cycle -> 0 every time.
//   4. Bypass: r3 holds 32'h1; in one cycle drive we=1 waddr=3 wdata=32'hA5A5_A5A5 with raddr1=raddr2=3, re1=re2=1 -> both ports 32'hA5A5_A5A5 before the edge; r3 updated after the edge.
//   5. Different-address read during write: write r9=32'h2 while reading r10=32'h10 -> port returns 32'h10.
//      Then write all 31 registers with value i*3 and read back -> each register returns i*3.
//   6. Mid-run reset: after test 5, assert rst for 1 cycle with a pending write to r4 -> all registers read 0 afterwards; r4 is not written.

Source files
------------

// File: rtl/regfile_wb.sv
// regfile_wb: general-purpose register file fed by the MEM/WB write-back triple.
// Two asynchronous read ports serve the ID stage. Register 0 reads as zero and
// has no storage. A write landing in the same cycle as a read of the same
// register is forwarded straight to the read port, which covers the
// distance-3 RAW hazard without a stall.
// NUM_REGS is expected to equal 2**ADDR_W.
module regfile_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    // Storage for registers 1..NUM_REGS-1 only; index 0 is synthesised away.
    logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

    // A write is committed only outside reset and never to register 0.
    logic wr_commit;
    assign wr_commit = !rst && we && (waddr != '0);

    // Next-state for the array: hold, clear on reset, or take the write-back data.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
        end else if (wr_commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    // Register array update; reset is folded into regs_d, so this is a plain register.
    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Array lookup for read port 1; a decoded mux avoids indexing the
    // nonexistent entry 0.
    logic [DATA_W-1:0] arr1;
    always_comb begin
        arr1 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) begin
                arr1 = regs_q[i];
            end
        end
    end

    // Array lookup for read port 2, same structure as port 1.
    logic [DATA_W-1:0] arr2;
    always_comb begin
        arr2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr2 == ADDR_W'(i)) begin
                arr2 = regs_q[i];
            end
        end
    end

    // Read port 1 priority: reset, r0, disabled, bypass, stored value.
    // Reset is tested first so X on enable/address cannot reach rdata1.
    always_comb begin
        rdata1 = '0;
        if (rst) begin
            rdata1 = '0;
        end else if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (!re1) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = arr1;
        end
    end

    // Read port 2 priority: identical to port 1.
    always_comb begin
        rdata2 = '0;
        if (rst) begin
            rdata2 = '0;
        end else if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (!re2) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = arr2;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: one task per scenario, inline checks.
module tb_regfile_wb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are changed and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'bx; raddr2 = 'x;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd1_during_rst: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd2_x_inputs: got %h want %h", rdata2, 32'h0);
        end
        tick(); tick();
        rst = 1'b0; we = 1'b0; re2 = 1'b1; raddr2 = 5'd5;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_r5_port1: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL reset_r5_port2: got %h want %h", rdata2, 32'h0);
        end
        tick();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL reset_r5_stays0: got %h want %h", rdata1, 32'h0);
        end
    endtask

    task automatic test_basic_write();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        re1 = 1'b0; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL basic_disabled_no_bypass: got %h want %h", rdata1, 32'h0);
        end
        tick();
        we = 1'b0; re1 = 1'b1;
        settle();
        n_checks++;
        if (rdata1 !== 32'h1234_5678) begin
            n_fail++; $display("FAIL basic_read_r7: got %h want %h", rdata1, 32'h1234_5678);
        end
        re1 = 1'b0; re2 = 1'b1;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL basic_re1_off: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'h1234_5678) begin
            n_fail++; $display("FAIL basic_read_r7_port2: got %h want %h", rdata2, 32'h1234_5678);
        end
        re2 = 1'b0;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_same_cycle_p1: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL zero_same_cycle_p2: got %h want %h", rdata2, 32'h0);
        end
        tick();
        we = 1'b0;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL zero_next_cycle_p1: got %h want %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'h0) begin
            n_fail++; $display("FAIL zero_next_cycle_p2: got %h want %h", rdata2, 32'h0);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd3; wdata = 32'h1; re1 = 1'b0; re2 = 1'b0;
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        settle();
        n_checks++;
        if (rdata1 !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL bypass_p1: got %h want %h", rdata1, 32'hA5A5_A5A5);
        end
        n_checks++;
        if (rdata2 !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL bypass_p2: got %h want %h", rdata2, 32'hA5A5_A5A5);
        end
        tick();
        we = 1'b0;
        settle();
        n_checks++;
        if (rdata1 !== 32'hA5A5_A5A5) begin
            n_fail++; $display("FAIL bypass_r3_updated: got %h want %h", rdata1, 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_diff_addr();
        logic [DATA_W-1:0] exp;
        we = 1'b1; waddr = 5'd10; wdata = 32'h10; re1 = 1'b0; re2 = 1'b0;
        tick();
        we = 1'b1; waddr = 5'd9; wdata = 32'h2;
        re1 = 1'b1; raddr1 = 5'd10; re2 = 1'b1; raddr2 = 5'd9;
        settle();
        n_checks++;
        if (rdata1 !== 32'h10) begin
            n_fail++; $display("FAIL diff_addr_old_r10: got %h want %h", rdata1, 32'h10);
        end
        n_checks++;
        if (rdata2 !== 32'h2) begin
            n_fail++; $display("FAIL diff_addr_bypass_r9: got %h want %h", rdata2, 32'h2);
        end
        tick();
        // Fill every register with i*3 while reads stay disabled.
        re1 = 1'b0; re2 = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            we = 1'b1; waddr = ADDR_W'(i); wdata = DATA_W'(i * 3);
            tick();
        end
        we = 1'b0; re1 = 1'b1; re2 = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(NUM_REGS - i);
            settle();
            exp = DATA_W'(i * 3);
            n_checks++;
            if (rdata1 !== exp) begin
                n_fail++; $display("FAIL fill_p1_r%0d: got %h want %h", i, rdata1, exp);
            end
            exp = DATA_W'((NUM_REGS - i) * 3);
            n_checks++;
            if (rdata2 !== exp) begin
                n_fail++; $display("FAIL fill_p2_r%0d: got %h want %h", NUM_REGS - i, rdata2, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Each cycle writes r(20+k)=k+100; port1 sees the bypass, port2 the previous write.
        re1 = 1'b1; re2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            we = 1'b1; waddr = ADDR_W'(20 + k); wdata = DATA_W'(k + 100);
            raddr1 = ADDR_W'(20 + k);
            raddr2 = ADDR_W'(19 + k);
            settle();
            n_checks++;
            if (rdata1 !== DATA_W'(k + 100)) begin
                n_fail++; $display("FAIL b2b_bypass_k%0d: got %h want %h", k, rdata1, DATA_W'(k + 100));
            end
            n_checks++;
            if (rdata2 !== ((k == 0) ? DATA_W'(19 * 3) : DATA_W'(k + 99))) begin
                n_fail++; $display("FAIL b2b_prev_k%0d: got %h want %h", k, rdata2,
                                   (k == 0) ? DATA_W'(19 * 3) : DATA_W'(k + 99));
            end
            tick();
        end
        we = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D;
        re1 = 1'b1; raddr1 = 5'd4; re2 = 1'b1; raddr2 = 5'd4;
        settle();
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++; $display("FAIL midrst_no_bypass: got %h want %h", rdata1, 32'h0);
        end
        tick();
        rst = 1'b0; we = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            raddr1 = ADDR_W'(i);
            settle();
            n_checks++;
            if (rdata1 !== 32'h0) begin
                n_fail++; $display("FAIL midrst_r%0d_cleared: got %h want %h", i, rdata1, 32'h0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        #2;
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_bypass();
        test_diff_addr();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
